mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: LATENCY, default 4, edges from request acceptance to response; legal range 1..15.
REQ-002 Parameter: ADDR_W, default 16, byte-address width; the array holds 2^(ADDR_W-1) 16-bit words.
REQ-003 Port: clk  in  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-005 Port: req_valid  in  1  initiator presents a request.
REQ-006 Port: req_wr  in  1  1 = write, 0 = read.
REQ-007 Port: req_addr  in  ADDR_W  byte address; word index = req_addr[ADDR_W-1:1], bit 0 ignored.
REQ-008 Port: req_wdata  in  16  write data.
REQ-009 Port: req_ready  out  1  responder can accept a request this cycle.
REQ-010 Port: rsp_valid  out  1  one-cycle response strobe.
REQ-011 Port: rsp_rdata  out  16  read data, qualified by rsp_valid.
REQ-012 Port: busy  out  1  high whenever a request is outstanding, i.e. state is not IDLE.

Function
REQ-013 The block SHALL implement states IDLE, WAIT and RESP; there SHALL be one outstanding request at most.
REQ-014 req_ready SHALL be high in IDLE and low in WAIT and RESP.
REQ-015 A request SHALL be accepted at a rising edge where req_valid and req_ready are both 1.
REQ-016 On acceptance, the block SHALL latch req_wr, the word index and req_wdata, load cnt = LATENCY-1 and enter WAIT.
REQ-017 Changes to the request inputs after acceptance SHALL have no effect on the outstanding operation.
REQ-018 In WAIT, each edge with cnt > 0 SHALL decrement cnt.
REQ-019 In WAIT, the edge with cnt == 0 SHALL enter RESP and perform the array access at that edge.
REQ-020 RESP SHALL therefore be entered exactly LATENCY edges after acceptance; WAIT lasts LATENCY cycles.
REQ-021 At the RESP-entry edge, a read SHALL register array[index] into rsp_rdata.
REQ-022 At the RESP-entry edge, a write SHALL store the latched wdata into array[index] and drive rsp_rdata = 16'h0000.
REQ-023 rsp_valid SHALL be high for exactly the one cycle spent in RESP; the next edge SHALL return to IDLE.
REQ-024 rsp_rdata SHALL hold its last value outside RESP; consumers SHALL sample it only with rsp_valid.
REQ-025 The earliest next acceptance SHALL be the edge ending the first IDLE cycle after RESP; sustained throughput is one request per LATENCY+2 cycles.
REQ-026 A read of an address written by the immediately preceding request SHALL return the new data.
REQ-027 req_valid asserted in WAIT or RESP SHALL be ignored; it is accepted only once IDLE is reached and it is still asserted.
REQ-028 Index wrap: the upper address bits beyond ADDR_W do not exist; every index value in 0..2^(ADDR_W-1)-1 SHALL be addressable with no aliasing inside that range.

Reset
REQ-029 While rst_n is 0, regardless of clk, the block SHALL force state = IDLE, cnt = 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 16'h0000 and busy = 0.
REQ-030 Reset SHALL NOT clear the memory array.
REQ-031 Reset asserted during WAIT or RESP SHALL abandon the operation; a write abandoned before its RESP-entry edge SHALL leave the array unmodified.
REQ-032 The first acceptance SHALL be possible at the first rising edge after rst_n deasserts.

Verification
REQ-033 LATENCY=4: write 0x0010 <- 0xBEEF accepted at edge E0 -> rsp_valid high only in the cycle after E4, rsp_rdata = 0x0000, busy high for cycles E0..E4, req_ready low for the same cycles.
REQ-034 Read 0x0010 issued right after REQ-033 -> accepted at edge E6, rsp_valid after E10, rsp_rdata = 0xBEEF.
REQ-035 LATENCY=1: read accepted at E0 -> rsp_valid in the cycle after E1; back-to-back requests with req_valid held high are accepted every 3 edges.
REQ-036 Read 0x0011 after writing 0x0010 -> returns the same word 0xBEEF (bit 0 ignored); writes to 0x0000 and 0xFFFE do not alias.
REQ-037 Inputs changed in WAIT (addr 0x0020, wdata 0x1234, req_valid toggled) -> original operation completes unaffected and no extra request is accepted.
REQ-038 rst_n pulsed low mid-WAIT of a write 0x0030 <- 0x5555 -> outputs take reset values immediately, no rsp_valid is produced, and a subsequent read of 0x0030 returns the prior contents.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - single-outstanding fixed-latency 16-bit word memory responder
//
// Accepts one read or write request at a time. A request is accepted while idle,
// waits LATENCY edges, accesses the word array on the last of those edges and
// returns a one-cycle response strobe.
//
// Parameters:
//   LATENCY  edges from request acceptance to response (1..15)
//   ADDR_W   byte-address width; array holds 2^(ADDR_W-1) 16-bit words
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset (array contents are preserved)
//   req_valid  request present
//   req_wr     1 = write, 0 = read
//   req_addr   byte address; bit 0 is ignored
//   req_wdata  write data
//   req_ready  high while idle; request accepted when req_valid && req_ready
//   rsp_valid  one-cycle response strobe
//   rsp_rdata  read data (0 for writes), held between responses
//   busy       high while a request is outstanding

module mem_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    input  logic              req_wr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [15:0]       req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [15:0]       rsp_rdata,
    output logic              busy
);

    localparam int DEPTH = 1 << (ADDR_W - 1);
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]        cnt;
    logic              op_wr;
    logic [ADDR_W-2:0] op_idx;
    logic [15:0]       op_wdata;
    logic              accept;
    logic              access;

    logic [15:0] mem [DEPTH];

    // Byte-lane select bit has no meaning for a 16-bit word array.
    logic unused_addr_lsb;
    assign unused_addr_lsb = req_addr[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        accept    = 1'b0;
        access    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // The edge that leaves WAIT is the one that touches the array,
                // so the response data is registered by the time RESP is visible.
                if (cnt == 4'd0) begin
                    access    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request fields are captured once at acceptance so later input activity
    // cannot disturb the outstanding operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 4'd0;
            op_wr     <= 1'b0;
            op_idx    <= '0;
            op_wdata  <= 16'h0000;
            rsp_rdata <= 16'h0000;
        end else begin
            if (accept) begin
                cnt      <= CNT_LOAD;
                op_wr    <= req_wr;
                op_idx   <= req_addr[ADDR_W-1:1];
                op_wdata <= req_wdata;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (access) begin
                rsp_rdata <= op_wr ? 16'h0000 : mem[op_idx];
            end
        end
    end

    // No reset on the array. access is derived from state, which the
    // asynchronous reset forces to IDLE, so an abandoned write never lands.
    always_ff @(posedge clk) begin
        if (access && op_wr && rst_n) begin
            mem[op_idx] <= op_wdata;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_wr;
    logic [15:0] req_addr, req_wdata;
    logic        req_ready, rsp_valid, busy;
    logic [15:0] rsp_rdata;

    logic        b_valid, b_wr;
    logic [15:0] b_addr, b_wdata;
    logic        b_ready, b_rsp_valid, b_busy;
    logic [15:0] b_rdata;

    mem_responder #(.LATENCY(4), .ADDR_W(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy)
    );

    mem_responder #(.LATENCY(1), .ADDR_W(16)) dut_l1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(b_valid), .req_wr(b_wr), .req_addr(b_addr), .req_wdata(b_wdata),
        .req_ready(b_ready), .rsp_valid(b_rsp_valid), .rsp_rdata(b_rdata), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic do_req(input int idx, input logic wr, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] exp);
        int   skipped;
        int   lat;
        logic side_ok;
        @(negedge clk);
        req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
        skipped = 0;
        while (!req_ready && skipped < 50) begin
            @(negedge clk);
            skipped++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_wr = ~wr; req_addr = ~addr; req_wdata = ~wdata;
        side_ok = 1'b1;
        lat = 0;
        while (!rsp_valid && lat < 40) begin
            if (!busy || req_ready) side_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        if (!busy || req_ready) side_ok = 1'b0;
        chk($sformatf("v%0d accept_wait", idx), skipped, 0);
        chk($sformatf("v%0d latency", idx), lat, 4);
        chk($sformatf("v%0d busy_ready", idx), side_ok, 1);
        chk($sformatf("v%0d rdata", idx), rsp_rdata, exp);
        @(posedge clk); #1;
        chk($sformatf("v%0d one_shot", idx), {rsp_valid, busy, req_ready}, 3'b001);
    endtask

    initial begin
        int          lat;
        logic        saw;
        logic [11:0] acc_mask, rsp_mask;

        vecs[0]  = '{1'b1, 16'h0010, 16'hBEEF, 16'h0000};
        vecs[1]  = '{1'b0, 16'h0010, 16'h0000, 16'hBEEF};
        vecs[2]  = '{1'b0, 16'h0011, 16'h0000, 16'hBEEF};
        vecs[3]  = '{1'b1, 16'h0000, 16'h1111, 16'h0000};
        vecs[4]  = '{1'b1, 16'hFFFE, 16'h2222, 16'h0000};
        vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 16'h1111};
        vecs[6]  = '{1'b0, 16'hFFFE, 16'h0000, 16'h2222};
        vecs[7]  = '{1'b1, 16'h0020, 16'h7777, 16'h0000};
        vecs[8]  = '{1'b1, 16'h0030, 16'hAAAA, 16'h0000};
        vecs[9]  = '{1'b1, 16'h8000, 16'h3333, 16'h0000};
        vecs[10] = '{1'b0, 16'h0000, 16'h0000, 16'h1111};
        vecs[11] = '{1'b0, 16'h8000, 16'h0000, 16'h3333};

        rst_n = 1'b0;
        req_valid = 1'b0; req_wr = 1'b0; req_addr = 16'h0; req_wdata = 16'h0;
        b_valid = 1'b0; b_wr = 1'b0; b_addr = 16'h0; b_wdata = 16'h0;
        #2;
        chk("reset outputs", {req_ready, rsp_valid, busy, rsp_rdata}, {3'b100, 16'h0000});
        chk("reset outputs l1", {b_ready, b_rsp_valid, b_busy, b_rdata}, {3'b100, 16'h0000});
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            do_req(i, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].exp);
        end

        // Inputs wiggled during WAIT must not affect the read in flight.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0010; req_wdata = 16'h0000;
        @(posedge clk); #1;
        chk("hold accepted", busy, 1);
        @(negedge clk);
        req_addr = 16'h0020; req_wdata = 16'h1234; req_wr = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        @(negedge clk); req_valid = 1'b1;
        @(negedge clk); req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("hold latency", lat, 1);
        chk("hold rdata", rsp_rdata, 16'hBEEF);
        saw = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            if (busy) saw = 1'b1;
        end
        chk("hold no extra accept", saw, 0);
        do_req(20, 1'b0, 16'h0020, 16'h0000, 16'h7777);

        // Reset in the middle of a write's WAIT phase.
        @(negedge clk);
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0030; req_wdata = 16'h5555;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst write accepted", busy, 1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("rst immediate", {req_ready, rsp_valid, busy, rsp_rdata}, {3'b100, 16'h0000});
        saw = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (rsp_valid || busy) saw = 1'b1;
        end
        chk("rst no response", saw, 0);
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = 1'b1; req_wr = 1'b0; req_addr = 16'h0030;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("first edge accept", busy, 1);
        lat = 0;
        while (!rsp_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("post-rst latency", lat, 4);
        chk("post-rst rdata", rsp_rdata, 16'hAAAA);
        @(posedge clk); #1;

        // LATENCY=1: held request accepted every third edge.
        acc_mask = '0;
        rsp_mask = '0;
        @(negedge clk);
        b_valid = 1'b1; b_wr = 1'b0; b_addr = 16'h0004;
        for (int k = 0; k < 12; k++) begin
            if (b_ready) acc_mask[k] = 1'b1;
            @(posedge clk); #1;
            if (b_rsp_valid) rsp_mask[k] = 1'b1;
            @(negedge clk);
        end
        b_valid = 1'b0;
        chk("l1 accept edges", acc_mask, 12'h249);
        chk("l1 response edges", rsp_mask, 12'h492);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
